// File: rtl/embedded_pio_arb_pkg.sv
// Shared constants and FSM state encoding for the multicore PIO read arbiter.
// Imported by the top-level arbiter and by the testbench.
package embedded_pio_arb_pkg;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/embedded_rr_arbiter.sv
// Combinational round-robin winner select: the first requester found after last_grant,
// wrapping modulo NUM_MASTERS. The grant pointer itself is held by the parent.
module embedded_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int LG_W        = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [LG_W-1:0]        last_grant,
  output logic [NUM_MASTERS-1:0] grant_onehot,
  output logic                   any_req
);

  // Rotational distance of a core from the slot just after last_grant (0 = top priority).
  function automatic int rr_dist(input int idx, input logic [LG_W-1:0] last);
    return (idx - int'(last) - 1 + 2 * NUM_MASTERS) % NUM_MASTERS;
  endfunction

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      grant_onehot[i] = req[i];
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (req[j] && (rr_dist(j, last_grant) < rr_dist(i, last_grant))) begin
          grant_onehot[i] = 1'b0;
        end
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/embedded_pio_read_arbiter.sv
// Shares one read-only PIO slave between NUM_MASTERS Avalon-MM read masters,
// granting round-robin and running one ISSUE/DATA/RESP transaction at a time.
module embedded_pio_read_arbiter
  import embedded_pio_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]             s_address,
  input  logic [DATA_W-1:0]             s_readdata,
  output logic                          busy,
  output arb_state_t                    fsm_state
);

  // Handshake: a core's command is accepted in the single cycle its m_waitrequest
  // is low (ISSUE); the response is the one-cycle m_readdatavalid strobe in RESP,
  // with m_readdata valid only alongside that strobe.

  localparam int LG_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t              state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q;
  logic [NUM_MASTERS-1:0]  win_onehot;
  logic                    any_req;
  logic                    take_grant;
  logic [LG_W-1:0]         last_grant;
  logic [LG_W-1:0]         win_idx;
  logic [ADDR_W-1:0]       win_addr;

  embedded_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .LG_W        (LG_W)
  ) u_rr (
    .req          (m_read),
    .last_grant   (last_grant),
    .grant_onehot (win_onehot),
    .any_req      (any_req)
  );

  // IDLE and RESP are the only decision points; RESP may chain straight into ISSUE.
  assign take_grant = ((state_q == IDLE) || (state_q == RESP)) && any_req;

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win_onehot[i]) begin
        win_idx  = LG_W'(i);
        win_addr = m_address[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = DATA;
      DATA:    state_d = RESP;
      RESP:    state_d = any_req ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      last_grant      <= LG_W'(NUM_MASTERS - 1);
      s_address       <= '0;
      m_readdata      <= '0;
      m_readdatavalid <= '0;
    end else begin
      state_q         <= state_d;
      m_readdatavalid <= '0;
      if (take_grant) begin
        grant_q    <= win_onehot;
        last_grant <= win_idx;
        s_address  <= win_addr;
      end
      // PIO readdata is registered, so it is valid during DATA and captured here.
      if (state_q == DATA) begin
        m_readdata      <= s_readdata;
        m_readdatavalid <= grant_q;
      end
    end
  end

  assign m_waitrequest = (state_q == ISSUE) ? ~grant_q : '1;
  assign busy          = (state_q != IDLE);
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_embedded_pio_read_arbiter.sv
// Bench for embedded_pio_read_arbiter (4 cores): directed scenarios followed by random
// traffic, checked against a transaction-schedule reference model and a data queue.
module tb_embedded_pio_read_arbiter;
  import embedded_pio_arb_pkg::*;

  localparam int NM   = 4;
  localparam int AW   = 2;
  localparam int DW   = 32;
  localparam int MAXC = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_read;
  logic [NM*AW-1:0] m_address;
  logic [NM-1:0]    m_waitrequest;
  logic [DW-1:0]    m_readdata;
  logic [NM-1:0]    m_readdatavalid;
  logic [AW-1:0]    s_address;
  logic [DW-1:0]    s_readdata;
  logic             busy;
  arb_state_t       fsm_state;
  logic [15:0]      in_port;

  embedded_pio_read_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m_read          (m_read),
    .m_address       (m_address),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .s_address       (s_address),
    .s_readdata      (s_readdata),
    .busy            (busy),
    .fsm_state       (fsm_state)
  );

  // PIO input slave: only register 0 is the input port, readdata registered one edge after address.
  always @(posedge clk) s_readdata <= (s_address == '0) ? {16'h0000, in_port} : '0;

  // ---------------- scoreboard / reference model ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  int            exp_wr  [MAXC];
  int            exp_rdv [MAXC];
  bit            exp_busy[MAXC];
  logic [AW-1:0] exp_sa;
  logic [DW-1:0] exp_rd;
  logic [DW-1:0] exp_q[$];
  int            next_dec;
  int            m_last;
  logic [NM-1:0] hold;
  int            acc_q[$];
  int            rdv_cnt[NM];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int rr_pick(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++) begin
      if (req[(last + k) % NM]) return (last + k) % NM;
    end
    return -1;
  endfunction

  // Schedules expected events from the request pattern seen at the end of cycle c.
  task automatic model_eval(input int c);
    int w;
    logic [AW-1:0] a;
    if (reset) begin
      for (int k = c + 1; k <= c + 4; k++) begin
        exp_wr[k] = 0; exp_rdv[k] = 0; exp_busy[k] = 0;
      end
      exp_q.delete();
      m_last   = NM - 1;
      next_dec = c + 1;
      exp_sa   = '0;
      exp_rd   = '0;
    end else if (c >= next_dec) begin
      w = rr_pick(m_read, m_last);
      if (w < 0) begin
        next_dec = c + 1;
      end else begin
        a = m_address[w*AW +: AW];
        m_last     = w;
        exp_wr[c+1]  = w + 1;
        exp_rdv[c+3] = w + 1;
        for (int k = c + 1; k <= c + 3; k++) exp_busy[k] = 1;
        exp_sa = a;
        exp_q.push_back((a == '0) ? {16'h0000, in_port} : '0);
        next_dec = c + 3;
      end
    end
  endtask

  task automatic do_checks(input int c);
    logic [NM-1:0] ewr, erdv;
    ewr  = '1;
    erdv = '0;
    if (exp_wr[c] != 0) ewr[exp_wr[c]-1] = 1'b0;
    if (exp_rdv[c] != 0) begin
      erdv[exp_rdv[c]-1] = 1'b1;
      if (exp_q.size() > 0) exp_rd = exp_q.pop_front();
    end
    check("waitrequest",   DW'(m_waitrequest),   DW'(ewr));
    check("readdatavalid", DW'(m_readdatavalid), DW'(erdv));
    check("readdata",      m_readdata,           exp_rd);
    check("busy",          DW'(busy),            DW'(exp_busy[c]));
    check("s_address",     DW'(s_address),       DW'(exp_sa));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [NM-1:0] acc;
    acc = m_read & ~m_waitrequest;
    model_eval(cyc);
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < NM; i++) begin
      if (acc[i] === 1'b1) begin
        m_read[i] = hold[i];
        acc_q.push_back(i);
      end
      if (m_readdatavalid[i] === 1'b1) rdv_cnt[i]++;
    end
    do_checks(cyc);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic request(input int core, input logic [AW-1:0] addr);
    m_read[core] = 1'b1;
    m_address[core*AW +: AW] = addr;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    m_read    = '0;
    m_address = '0;
    hold      = '0;
    in_port   = 16'hBEEF;
    for (int i = 0; i < NM; i++) rdv_cnt[i] = 0;
    ticks(3);
    reset = 1'b0;
    tick();

    // single master: core0 reads register 0
    request(0, 2'd0);
    tick();
    check("single_wr_c1", DW'(m_waitrequest), DW'(4'b1110));
    check("single_busy_c1", DW'(busy), 32'd1);
    ticks(2);
    check("single_rdv_c3", DW'(m_readdatavalid), DW'(4'b0001));
    check("single_data_c3", m_readdata, 32'h0000BEEF);
    ticks(2);
    check("single_hold_idle", m_readdata, 32'h0000BEEF);

    // simultaneous first requests from cores 0 and 1
    reset_pulse();
    request(0, 2'd0);
    request(1, 2'd0);
    ticks(3);
    check("simul_rdv0_c3", DW'(m_readdatavalid), DW'(4'b0001));
    check("simul_wr1_c3", DW'(m_waitrequest[1]), 32'd1);
    tick();
    check("simul_wr1_c4", DW'(m_waitrequest[1]), 32'd0);
    ticks(2);
    check("simul_rdv1_c6", DW'(m_readdatavalid), DW'(4'b0010));
    ticks(2);

    // fairness: cores 0 and 1 request continuously for 8 transactions
    reset_pulse();
    acc_q.delete();
    for (int i = 0; i < NM; i++) rdv_cnt[i] = 0;
    hold = 4'b0011;
    request(0, 2'd0);
    request(1, 2'd0);
    ticks(24);
    hold   = '0;
    m_read = '0;
    check("fair_rdv_core0", DW'(rdv_cnt[0]), 32'd4);
    check("fair_rdv_core1", DW'(rdv_cnt[1]), 32'd4);
    check("fair_acc_count", DW'(acc_q.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < acc_q.size(); k++) check("fair_order", DW'(acc_q[k]), DW'(k % 2));
    ticks(3);

    // address pass-through: nonzero address returns 0
    in_port = 16'h1234;
    request(1, 2'd2);
    tick();
    check("addr_sa_c1", DW'(s_address), 32'd2);
    tick();
    check("addr_sa_c2", DW'(s_address), 32'd2);
    tick();
    check("addr_rdv_c3", DW'(m_readdatavalid), DW'(4'b0010));
    check("addr_data_c3", m_readdata, 32'h0);
    ticks(2);

    // request dropped during ISSUE still completes
    request(2, 2'd0);
    tick();
    m_read[2] = 1'b0;
    ticks(2);
    check("drop_rdv_c3", DW'(m_readdatavalid), DW'(4'b0100));
    check("drop_data_c3", m_readdata, 32'h00001234);
    ticks(2);

    // reset asserted in DATA aborts without a strobe
    request(0, 2'd0);
    ticks(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_rdv", DW'(m_readdatavalid), 32'd0);
    check("rst_wr", DW'(m_waitrequest), DW'(4'b1111));
    check("rst_busy", DW'(busy), 32'd0);
    check("rst_data", m_readdata, 32'd0);
    acc_q.delete();
    request(1, 2'd0);
    request(0, 2'd0);
    ticks(7);
    check("rst_first_grant", DW'((acc_q.size() > 0) ? acc_q[0] : -1), 32'd0);
    ticks(2);

    // pointer wrap: last grant 3, cores 1 and 3 requesting
    reset_pulse();
    acc_q.delete();
    hold = 4'b1010;
    request(1, 2'd0);
    request(3, 2'd0);
    ticks(9);
    hold   = '0;
    m_read = '0;
    check("wrap_acc_count", DW'(acc_q.size() >= 3), 32'd1);
    for (int k = 0; k < 3 && k < acc_q.size(); k++) check("wrap_order", DW'(acc_q[k]), (k == 1) ? 32'd3 : 32'd1);
    ticks(3);

    // random traffic with occasional resets
    in_port = 16'($urandom);
    for (int t = 0; t < 700; t++) begin
      for (int i = 0; i < NM; i++) begin
        if (!m_read[i] && ($urandom_range(0, 2) == 0)) request(i, AW'($urandom_range(0, 3)));
      end
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset  = 1'b0;
    m_read = '0;
    ticks(6);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
